// File: rtl/vx_perf_ctr_bank.sv
// Bank of event counters with shadow snapshot registers and a single-entry
// valid/ready read port for live or shadow values.
module vx_perf_ctr_bank #(
  parameter int NUM_CTRS  = 16,
  parameter int CTR_WIDTH = 44,
  parameter int INC_WIDTH = 4,
  parameter int SATURATE  = 0,
  localparam int IDX_W    = (NUM_CTRS > 1) ? $clog2(NUM_CTRS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_CTRS*INC_WIDTH-1:0] inc,
  input  logic                          clear,
  input  logic                          snap,
  input  logic                          req_valid,
  input  logic [IDX_W-1:0]              req_idx,
  input  logic                          req_shadow,
  output logic                          req_ready,
  output logic                          rsp_valid,
  output logic [CTR_WIDTH-1:0]          rsp_data,
  input  logic                          rsp_ready,
  output logic [NUM_CTRS-1:0]           overflow
);

  logic [CTR_WIDTH-1:0] ctr_q    [NUM_CTRS];
  logic [CTR_WIDTH-1:0] ctr_d    [NUM_CTRS];
  logic [CTR_WIDTH-1:0] shadow_q [NUM_CTRS];
  logic [CTR_WIDTH-1:0] shadow_d [NUM_CTRS];
  logic [NUM_CTRS-1:0]  ovf_q, ovf_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [CTR_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [CTR_WIDTH-1:0] sel_data;
  logic [CTR_WIDTH:0]   sum;
  logic                 fire;

  // Shadow capture uses the registered value, so snap+clear samples the
  // interval that is just ending.
  always_comb begin
    ctr_d    = ctr_q;
    shadow_d = shadow_q;
    ovf_d    = ovf_q;
    sum      = '0;
    for (int i = 0; i < NUM_CTRS; i++) begin
      sum = {1'b0, ctr_q[i]} + (CTR_WIDTH+1)'(inc[i*INC_WIDTH +: INC_WIDTH]);
      if (snap) shadow_d[i] = ctr_q[i];
      if (clear) begin
        ctr_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (enable) begin
        if (sum[CTR_WIDTH]) begin
          ovf_d[i] = 1'b1;
          ctr_d[i] = (SATURATE != 0) ? '1 : sum[CTR_WIDTH-1:0];
        end else begin
          ctr_d[i] = sum[CTR_WIDTH-1:0];
        end
      end
    end
  end

  // Out-of-range indices match no channel and read back as zero.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CTRS; i++) begin
      if (req_idx == IDX_W'(i)) sel_data = req_shadow ? shadow_q[i] : ctr_q[i];
    end
  end

  assign req_ready = !rsp_valid_q || rsp_ready;

  always_comb begin
    fire        = req_valid && req_ready;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    if (fire) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = sel_data;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CTRS; i++) begin
        ctr_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      ovf_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      ctr_q       <= ctr_d;
      shadow_q    <= shadow_d;
      ovf_q       <= ovf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_vx_perf_ctr_bank.sv
// Scoreboard bench: a wrapping and a saturating bank driven with identical
// stimulus, checked against an arithmetic reference model.
module tb_vx_perf_ctr_bank;
  localparam int N    = 5;
  localparam int CW   = 8;
  localparam int IW   = 4;
  localparam int IDXW = 3;
  localparam int MAXV = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, enable, clear, snap, req_valid, req_shadow, rsp_ready;
  logic [N*IW-1:0] inc;
  logic [IDXW-1:0] req_idx;
  logic            req_ready0, rsp_valid0, req_ready1, rsp_valid1;
  logic [CW-1:0]   rsp_data0, rsp_data1;
  logic [N-1:0]    ovf0, ovf1;

  vx_perf_ctr_bank #(.NUM_CTRS(N), .CTR_WIDTH(CW), .INC_WIDTH(IW), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .enable(enable), .inc(inc), .clear(clear), .snap(snap),
    .req_valid(req_valid), .req_idx(req_idx), .req_shadow(req_shadow),
    .req_ready(req_ready0), .rsp_valid(rsp_valid0), .rsp_data(rsp_data0),
    .rsp_ready(rsp_ready), .overflow(ovf0));

  vx_perf_ctr_bank #(.NUM_CTRS(N), .CTR_WIDTH(CW), .INC_WIDTH(IW), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .inc(inc), .clear(clear), .snap(snap),
    .req_valid(req_valid), .req_idx(req_idx), .req_shadow(req_shadow),
    .req_ready(req_ready1), .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
    .rsp_ready(rsp_ready), .overflow(ovf1));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: index 0 wraps, index 1 saturates.
  int m_ctr [2][N];
  int m_sh  [2][N];
  bit m_ovf [2][N];
  bit m_pend;
  int q0[$];
  int q1[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_read(input int k);
    if (int'(req_idx) < N)
      return req_shadow ? m_sh[k][req_idx] : m_ctr[k][req_idx];
    return 0;
  endfunction

  function automatic int ovf_vec(input int k);
    int v = 0;
    for (int i = 0; i < N; i++) if (m_ovf[k][i]) v |= (1 << i);
    return v;
  endfunction

  task automatic step();
    bit fire;
    int s;
    fire = req_valid && (!m_pend || rsp_ready);
    if (fire && !reset) begin
      q0.push_back(exp_read(0));
      q1.push_back(exp_read(1));
    end
    @(posedge clk);
    #1;
    if (reset) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < N; i++) begin
          m_ctr[k][i] = 0; m_sh[k][i] = 0; m_ovf[k][i] = 0;
        end
      m_pend = 0;
      q0.delete();
      q1.delete();
    end else begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < N; i++) begin
          if (snap) m_sh[k][i] = m_ctr[k][i];
          if (clear) begin
            m_ctr[k][i] = 0;
            m_ovf[k][i] = 0;
          end else if (enable) begin
            s = m_ctr[k][i] + int'(inc[i*IW +: IW]);
            if (s > MAXV) begin
              m_ovf[k][i] = 1;
              m_ctr[k][i] = (k == 1) ? MAXV : s - (MAXV + 1);
            end else begin
              m_ctr[k][i] = s;
            end
          end
        end
      m_pend = fire ? 1'b1 : (rsp_ready ? 1'b0 : m_pend);
    end
    chk("rsp_valid_wrap", int'(rsp_valid0), int'(m_pend));
    chk("rsp_valid_sat",  int'(rsp_valid1), int'(m_pend));
    chk("req_ready_wrap", int'(req_ready0), int'(!m_pend || rsp_ready));
    chk("req_ready_sat",  int'(req_ready1), int'(!m_pend || rsp_ready));
    chk("overflow_wrap",  int'(ovf0), ovf_vec(0));
    chk("overflow_sat",   int'(ovf1), ovf_vec(1));
  endtask

  task automatic idle();
    reset = 0; enable = 0; clear = 0; snap = 0; inc = '0;
    req_valid = 0; req_idx = '0; req_shadow = 0; rsp_ready = 1;
  endtask

  task automatic set_inc(input int ch, input int val);
    inc[ch*IW +: IW] = IW'(val);
  endtask

  task automatic read(input int idx, input bit sh);
    req_valid = 1; req_idx = IDXW'(idx); req_shadow = sh;
    step();
    req_valid = 0;
  endtask

  // Monitor: consumes responses on handshake and checks hold under backpressure.
  bit            held0 = 0, held1 = 0;
  logic [CW-1:0] hd0, hd1;
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (held0 && rsp_valid0) chk("hold_wrap", int'(rsp_data0), int'(hd0));
      if (held1 && rsp_valid1) chk("hold_sat",  int'(rsp_data1), int'(hd1));
      if (rsp_valid0 === 1'b1 && rsp_ready === 1'b1) begin
        if (q0.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rsp_unexpected_wrap: got data %0d expected no response", rsp_data0);
        end else begin
          e = q0.pop_front();
          chk("rsp_data_wrap", int'(rsp_data0), e);
        end
      end
      if (rsp_valid1 === 1'b1 && rsp_ready === 1'b1) begin
        if (q1.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rsp_unexpected_sat: got data %0d expected no response", rsp_data1);
        end else begin
          e = q1.pop_front();
          chk("rsp_data_sat", int'(rsp_data1), e);
        end
      end
      held0 = (rsp_valid0 === 1'b1) && (rsp_ready === 1'b0);
      held1 = (rsp_valid1 === 1'b1) && (rsp_ready === 1'b0);
      hd0 = rsp_data0;
      hd1 = rsp_data1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    m_pend = 0;
    reset = 1;
    step(); step();
    reset = 0;
    for (int i = 0; i < N; i++) begin read(i, 0); read(i, 1); end

    // counting on one channel
    enable = 1; set_inc(2, 3);
    repeat (5) step();
    enable = 0; inc = '0;
    for (int i = 0; i < N; i++) read(i, 0);

    // wrap vs saturate: 254 + 3
    reset = 1; step(); reset = 0;
    enable = 1; set_inc(0, 15);
    repeat (16) step();
    set_inc(0, 14); step();
    set_inc(0, 3);  step();
    enable = 0; inc = '0;
    read(0, 0);
    enable = 1; set_inc(0, 3); step();
    enable = 0; inc = '0;
    read(0, 0);

    // snap and clear in the same cycle
    clear = 1; step(); clear = 0;
    enable = 1; set_inc(0, 10);
    repeat (10) step();
    set_inc(0, 5); snap = 1; clear = 1; step();
    snap = 0; clear = 0; step();
    enable = 0; inc = '0;
    read(0, 1); read(0, 0);

    // backpressure with a competing request held off
    enable = 1; set_inc(1, 7);
    req_valid = 1; req_idx = 1; req_shadow = 0; rsp_ready = 0;
    step();
    req_idx = 2;
    repeat (3) step();
    rsp_ready = 1; req_idx = 0; req_shadow = 1;
    step();
    req_valid = 0; step();
    enable = 0; inc = '0;

    // out-of-range indices
    read(5, 0); read(7, 1); read(6, 0);

    // randomized traffic
    repeat (800) begin
      reset      = ($urandom_range(199) == 0);
      clear      = ($urandom_range(29) == 0);
      snap       = ($urandom_range(7) == 0);
      enable     = ($urandom_range(3) != 0);
      inc        = (N*IW)'($urandom());
      req_valid  = ($urandom_range(1) == 1);
      req_idx    = IDXW'($urandom_range(7));
      req_shadow = ($urandom_range(1) == 1);
      rsp_ready  = ($urandom_range(2) != 0);
      step();
    end

    // reset while a response is pending and counters are nonzero
    idle();
    enable = 1;
    for (int i = 0; i < N; i++) set_inc(i, 9);
    repeat (3) step();
    snap = 1; step(); snap = 0;
    req_valid = 1; req_idx = 3; req_shadow = 0; rsp_ready = 0;
    step();
    req_valid = 0; reset = 1;
    step();
    idle();
    for (int i = 0; i < N; i++) begin read(i, 0); read(i, 1); end

    idle();
    repeat (4) step();
    chk("queue_drained_wrap", q0.size(), 0);
    chk("queue_drained_sat",  q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
